// File: rtl/dma_pkg.sv
// Shared DMA constants: default datapath width and FIFO depth used by every channel.
package dma_pkg;

    localparam int DMA_DATA_W     = 32;
    localparam int DMA_FIFO_DEPTH = 16;

endpackage : dma_pkg

// File: rtl/dma_fifo_ram.sv
// Simple dual-port storage for the DMA FIFO: synchronous write, registered read.
// The array itself carries no reset; only the read register is cleared.
module dma_fifo_ram #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read register holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : dma_fifo_ram

// File: rtl/dma_param_fifo.sv
// Parametrised single-clock FIFO between the DMA bus-read and bus-write engines,
// with fill level, watermarks, synchronous flush and sticky error flags.
module dma_param_fifo
    import dma_pkg::*;
#(
    parameter int  DATA_W = DMA_DATA_W,
    parameter int  DEPTH  = DMA_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_w,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_r,
    output logic              r_valid,
    output logic [CNT_W-1:0]  level,
    output logic              empty,
    output logic              full,
    input  logic [CNT_W-1:0]  af_thresh,
    input  logic [CNT_W-1:0]  ae_thresh,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_level;
    logic [CNT_W-1:0]  w_level_next;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_rdata;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == CNT_W'(DEPTH));
    assign w_wr_acc = w_en & ~w_full  & ~flush;
    assign w_rd_acc = r_en & ~w_empty & ~flush;

    always_comb begin
        w_level_next = r_level;
        if (flush) begin
            w_level_next = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_level_next = r_level + CNT_W'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_next = r_level - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_level    <= w_level_next;
            r_rd_valid <= w_rd_acc;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && w_full && !flush)       r_overflow <= 1'b1;
            else if (clr_err)                   r_overflow <= 1'b0;
            if (r_en && w_empty && !flush)      r_underflow <= 1'b1;
            else if (clr_err)                   r_underflow <= 1'b0;
        end
    end

    dma_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (data_w),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign data_r       = w_rdata;
    assign r_valid      = r_rd_valid;
    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_level >= af_thresh);
    assign almost_empty = (r_level <= ae_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : dma_param_fifo

// File: tb/tb_dma_param_fifo.sv
// Self-checking bench for dma_param_fifo (DATA_W=32, DEPTH=16): vector table,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_dma_param_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          w_en;
    logic [DW-1:0] data_w;
    logic          r_en;
    logic [DW-1:0] data_r;
    logic          r_valid;
    logic [CW-1:0] level;
    logic          empty;
    logic          full;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    dma_param_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .w_en         (w_en),
        .data_w       (data_w),
        .r_en         (r_en),
        .data_r       (data_r),
        .r_valid      (r_valid),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: contents as a queue, outputs as plain variables.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovf;
    logic          m_udf;

    typedef struct {
        logic          f;
        logic          we;
        logic          re;
        logic [DW-1:0] d;
        logic          clr;
        int            exp_level;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic model_update(input logic f, input logic we, input logic re,
                                input logic [DW-1:0] d, input logic clr);
        bit was_full;
        bit was_empty;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (f) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            if (we && was_full)  m_ovf = 1'b1;
            if (re && was_empty) m_udf = 1'b1;
            m_valid = re && !was_empty;
            if (m_valid) m_data = m_q.pop_front();
            if (we && !was_full) m_q.push_back(d);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("level", DW'(level), DW'(n));
        chk("full", DW'(full), DW'(n == DEPTH));
        chk("empty", DW'(empty), DW'(n == 0));
        chk("r_valid", DW'(r_valid), DW'(m_valid));
        chk("data_r", data_r, m_data);
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("underflow", DW'(underflow), DW'(m_udf));
        chk("almost_full", DW'(almost_full), DW'(n >= int'(af_thresh)));
        chk("almost_empty", DW'(almost_empty), DW'(n <= int'(ae_thresh)));
    endtask

    task automatic step(input logic f, input logic we, input logic re,
                        input logic [DW-1:0] d, input logic clr, input bit do_chk);
        flush   = f;
        w_en    = we;
        r_en    = re;
        data_w  = d;
        clr_err = clr;
        @(posedge clk);
        model_update(f, we, re, d, clr);
        #1;
        if (do_chk) check_model();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_w = '0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(input logic f, input logic we, input logic re, input logic [DW-1:0] d,
                                input logic clr, input int lv, input logic v, input logic [DW-1:0] dr,
                                input logic o, input logic u);
        vec_t t;
        t.f = f; t.we = we; t.re = re; t.d = d; t.clr = clr;
        t.exp_level = lv; t.exp_valid = v; t.exp_data = dr; t.exp_ovf = o; t.exp_udf = u;
        return t;
    endfunction

    initial begin
        af_thresh = 5'd2;
        ae_thresh = 5'd1;
        apply_reset();
        check_model();
        chk("reset_data_r", data_r, 32'h0);

        // Empty with simultaneous read/write, set-wins-over-clear, flush with write.
        tbl[0] = mk(0, 1, 1, 32'hA5A5A5A5, 0, 1, 0, 32'h0,        0, 1);
        tbl[1] = mk(0, 0, 1, 32'h0,        0, 0, 1, 32'hA5A5A5A5, 0, 1);
        tbl[2] = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'hA5A5A5A5, 0, 0);
        tbl[3] = mk(0, 1, 0, 32'h11,       0, 1, 0, 32'hA5A5A5A5, 0, 0);
        tbl[4] = mk(0, 1, 0, 32'h22,       0, 2, 0, 32'hA5A5A5A5, 0, 0);
        tbl[5] = mk(0, 1, 1, 32'h33,       0, 2, 1, 32'h11,       0, 0);
        tbl[6] = mk(1, 1, 1, 32'h44,       0, 0, 0, 32'h11,       0, 0);
        tbl[7] = mk(0, 0, 1, 32'h0,        0, 0, 0, 32'h11,       0, 1);
        tbl[8] = mk(0, 0, 1, 32'h0,        1, 0, 0, 32'h11,       0, 1);
        tbl[9] = mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h11,       0, 0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].f, tbl[i].we, tbl[i].re, tbl[i].d, tbl[i].clr, 1'b0);
            $display("vec %0d: f=%0b w=%0b r=%0b d=%h clr=%0b -> level=%0d r_valid=%0b data_r=%h ovf=%0b udf=%0b",
                     i, tbl[i].f, tbl[i].we, tbl[i].re, tbl[i].d, tbl[i].clr,
                     level, r_valid, data_r, overflow, underflow);
            chk("vec_level", DW'(level), DW'(tbl[i].exp_level));
            chk("vec_r_valid", DW'(r_valid), DW'(tbl[i].exp_valid));
            chk("vec_data_r", data_r, tbl[i].exp_data);
            chk("vec_overflow", DW'(overflow), DW'(tbl[i].exp_ovf));
            chk("vec_underflow", DW'(underflow), DW'(tbl[i].exp_udf));
        end

        // Fill to full, overflow, clear interplay, drain in order.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h1000 + DW'(i), 0, 1'b1);
        chk("fill_full", DW'(full), 32'd1);
        chk("fill_level", DW'(level), 32'd16);
        step(0, 1, 0, 32'hDEAD0000, 0, 1'b1);
        chk("ovf_level", DW'(level), 32'd16);
        chk("ovf_set", DW'(overflow), 32'd1);
        step(0, 1, 0, 32'hDEAD0001, 1, 1'b1);
        chk("ovf_clr_collide", DW'(overflow), 32'd1);
        step(0, 0, 0, 32'h0, 1, 1'b1);
        chk("ovf_clr_alone", DW'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 32'h0, 0, 1'b1);
            chk("drain_data", data_r, 32'h1000 + DW'(i));
        end
        chk("drain_empty", DW'(empty), 32'd1);

        // Steady-state streaming across pointer wrap.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 32'h2000 + DW'(i), 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 32'h2008 + DW'(i), 0, 1'b1);
            chk("stream_level", DW'(level), 32'd8);
            chk("stream_data", data_r, 32'h2000 + DW'(i));
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h0, 0, 1'b1);

        // Watermarks.
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        #1;
        check_model();
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 32'h3000 + DW'(i), 0, 1'b1);
            chk("af_edge", DW'(almost_full), DW'(i + 1 >= 12));
        end
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 32'h0, 0, 1'b1);
            chk("ae_edge", DW'(almost_empty), DW'(12 - (i + 1) <= 3));
        end
        af_thresh = 5'd0;
        ae_thresh = 5'd16;
        #1;
        chk("af_zero_forced", DW'(almost_full), 32'd1);
        chk("ae_depth_forced", DW'(almost_empty), 32'd1);

        // Flush at level 10 together with a write.
        af_thresh = 5'd10;
        ae_thresh = 5'd2;
        for (int i = 0; i < 7; i++) step(0, 1, 0, 32'h4000 + DW'(i), 0, 1'b1);
        chk("pre_flush_level", DW'(level), 32'd10);
        step(1, 1, 0, 32'h4444, 0, 1'b1);
        chk("flush_level", DW'(level), 32'd0);
        chk("flush_data_hold", data_r, 32'h3008);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic f, we, re, clr;
            if ((i % 50) == 0) begin
                af_thresh = CW'($urandom_range(0, 18));
                ae_thresh = CW'($urandom_range(0, 18));
            end
            f   = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 19) == 0);
            we  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            re  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            step(f, we, re, DW'($urandom), clr, 1'b1);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 32'h5000 + DW'(i), 0, 1'b0);
        step(0, 0, 1, 32'h0, 0, 1'b0);
        w_en = 1'b1; data_w = 32'h6000;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_level", DW'(level), 32'd0);
        chk("arst_empty", DW'(empty), 32'd1);
        chk("arst_full", DW'(full), 32'd0);
        chk("arst_data_r", data_r, 32'h0);
        chk("arst_r_valid", DW'(r_valid), 32'd0);
        chk("arst_overflow", DW'(overflow), 32'd0);
        chk("arst_underflow", DW'(underflow), 32'd0);
        w_en = 1'b0;
        #2 rst_n = 1'b1;
        step(0, 0, 1, 32'h0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dma_param_fifo
